// File: rtl/gerenciador_projeteis.sv
// Projectile pool for the VGA game: NUM_BOLAS slots that spawn on fire requests,
// advance on a divided movement tick and retire on target hit or screen exit.
module gerenciador_projeteis #(
  parameter int NUM_BOLAS   = 4,
  parameter int DIV_TICK    = 200000,
  parameter int VEL         = 5,
  parameter int RAIO        = 5,
  parameter int OFFSET_X    = 159,
  parameter int OFFSET_Y    = 35,
  parameter int Y_MIN       = 35,
  parameter int Y_MAX       = 514,
  parameter int POS_INATIVA = 1000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    pausa,
  input  logic                    reiniciarJogo,
  input  logic                    disparar,
  input  logic [9:0]              xi,
  input  logic [9:0]              yi,
  input  logic                    ehAliada,
  input  logic [9:0]              alvo_x,
  input  logic [9:0]              alvo_y,
  input  logic [9:0]              alvo_l,
  input  logic [9:0]              alvo_a,
  output logic [10*NUM_BOLAS-1:0] bola_x,
  output logic [10*NUM_BOLAS-1:0] bola_y,
  output logic [NUM_BOLAS-1:0]    ativa,
  output logic [NUM_BOLAS-1:0]    aliada,
  output logic                    disparo_aceito,
  output logic                    disparo_recusado,
  output logic [NUM_BOLAS-1:0]    acerto,
  output logic [NUM_BOLAS-1:0]    saiu,
  output logic [9:0]              raio
);

  localparam int CW = $clog2(DIV_TICK);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV_TICK - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [9:0]    POS10     = 10'(POS_INATIVA);
  localparam logic [9:0]    VEL10     = 10'(VEL);
  localparam logic [9:0]    OFFX10    = 10'(OFFSET_X);
  localparam logic [9:0]    OFFY10    = 10'(OFFSET_Y);
  localparam logic [10:0]   RAIO11    = 11'(RAIO);
  localparam logic [10:0]   VEL11     = 11'(VEL);
  localparam logic [10:0]   YMAX11    = 11'(Y_MAX);
  localparam logic [10:0]   MIN_ALLY  = 11'(Y_MIN + VEL);

  logic [CW-1:0]          cont_q, cont_d;
  logic                   tick;
  logic [9:0]             x_q [NUM_BOLAS];
  logic [9:0]             x_d [NUM_BOLAS];
  logic [9:0]             y_q [NUM_BOLAS];
  logic [9:0]             y_d [NUM_BOLAS];
  logic [NUM_BOLAS-1:0]   ativa_q, ativa_d, aliada_q, aliada_d;
  logic [NUM_BOLAS-1:0]   acerto_q, acerto_d, saiu_q, saiu_d;
  logic [NUM_BOLAS-1:0]   spawn_sel, overlap;
  logic                   aceito_q, aceito_d, recusado_q, recusado_d;
  logic                   fire_ok, livre_visto;
  logic [10:0]            lim_x, lim_y, bx, by;

  always_comb begin
    tick   = !pausa && (cont_q == CNT_MAX);
    cont_d = cont_q;
    if (!pausa) cont_d = tick ? '0 : cont_q + CNT_ONE;
  end

  // Box test widened to 11 bits so the radius margin never wraps near 1023.
  always_comb begin
    lim_x   = {1'b0, alvo_x} + {1'b0, alvo_l} + RAIO11;
    lim_y   = {1'b0, alvo_y} + {1'b0, alvo_a} + RAIO11;
    overlap = '0;
    bx      = '0;
    by      = '0;
    for (int i = 0; i < NUM_BOLAS; i++) begin
      bx = {1'b0, x_q[i]};
      by = {1'b0, y_q[i]};
      overlap[i] = (bx + RAIO11 >= {1'b0, alvo_x}) && (bx <= lim_x) &&
                   (by + RAIO11 >= {1'b0, alvo_y}) && (by <= lim_y);
    end
  end

  // Free-slot search uses start-of-cycle flags, so a slot retired now is reused next cycle.
  always_comb begin
    spawn_sel   = '0;
    livre_visto = 1'b0;
    for (int i = 0; i < NUM_BOLAS; i++) begin
      if (!ativa_q[i] && !livre_visto) begin
        spawn_sel[i] = 1'b1;
        livre_visto  = 1'b1;
      end
    end
  end

  always_comb begin
    fire_ok    = disparar && !pausa && !reset && !reiniciarJogo;
    x_d        = x_q;
    y_d        = y_q;
    ativa_d    = ativa_q;
    aliada_d   = aliada_q;
    acerto_d   = '0;
    saiu_d     = '0;
    aceito_d   = fire_ok && (|spawn_sel);
    recusado_d = fire_ok && !(|spawn_sel);
    for (int i = 0; i < NUM_BOLAS; i++) begin
      if (reiniciarJogo) begin
        ativa_d[i]  = 1'b0;
        aliada_d[i] = 1'b0;
        x_d[i]      = POS10;
        y_d[i]      = POS10;
      end else if (ativa_q[i] && overlap[i]) begin
        ativa_d[i]  = 1'b0;
        aliada_d[i] = 1'b0;
        x_d[i]      = POS10;
        y_d[i]      = POS10;
        acerto_d[i] = 1'b1;
      end else if (tick && ativa_q[i]) begin
        if (aliada_q[i] ? ({1'b0, y_q[i]} < MIN_ALLY)
                        : ({1'b0, y_q[i]} + VEL11 > YMAX11)) begin
          ativa_d[i]  = 1'b0;
          aliada_d[i] = 1'b0;
          x_d[i]      = POS10;
          y_d[i]      = POS10;
          saiu_d[i]   = 1'b1;
        end else if (aliada_q[i]) begin
          y_d[i] = y_q[i] - VEL10;
        end else begin
          y_d[i] = y_q[i] + VEL10;
        end
      end else if (fire_ok && spawn_sel[i]) begin
        ativa_d[i]  = 1'b1;
        aliada_d[i] = ehAliada;
        x_d[i]      = xi + OFFX10;
        y_d[i]      = yi + OFFY10;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cont_q     <= '0;
      ativa_q    <= '0;
      aliada_q   <= '0;
      acerto_q   <= '0;
      saiu_q     <= '0;
      aceito_q   <= 1'b0;
      recusado_q <= 1'b0;
      for (int i = 0; i < NUM_BOLAS; i++) begin
        x_q[i] <= POS10;
        y_q[i] <= POS10;
      end
    end else begin
      cont_q     <= cont_d;
      ativa_q    <= ativa_d;
      aliada_q   <= aliada_d;
      acerto_q   <= acerto_d;
      saiu_q     <= saiu_d;
      aceito_q   <= aceito_d;
      recusado_q <= recusado_d;
      for (int i = 0; i < NUM_BOLAS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_BOLAS; g++) begin : g_pack
    assign bola_x[10*g +: 10] = x_q[g];
    assign bola_y[10*g +: 10] = y_q[g];
  end

  assign ativa            = ativa_q;
  assign aliada           = aliada_q;
  assign acerto           = acerto_q;
  assign saiu             = saiu_q;
  assign disparo_aceito   = aceito_q;
  assign disparo_recusado = recusado_q;
  assign raio             = 10'(RAIO);

endmodule

// File: tb/tb_gerenciador_projeteis.sv
// Scenario bench for gerenciador_projeteis with a fast movement tick (DIV_TICK=4).
module tb_gerenciador_projeteis;

  localparam int NB = 4;
  localparam int DT = 4;

  logic          clk = 1'b0;
  logic          reset, pausa, reiniciarJogo, disparar, ehAliada;
  logic [9:0]    xi, yi, alvo_x, alvo_y, alvo_l, alvo_a;
  logic [10*NB-1:0] bola_x, bola_y;
  logic [NB-1:0] ativa, aliada, acerto, saiu;
  logic          disparo_aceito, disparo_recusado;
  logic [9:0]    raio;

  int checks = 0;
  int passes = 0;
  logic [15:0] exp_q[$];

  gerenciador_projeteis #(.NUM_BOLAS(NB), .DIV_TICK(DT)) dut (
    .CLOCK_50(clk), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .disparar(disparar), .xi(xi), .yi(yi), .ehAliada(ehAliada),
    .alvo_x(alvo_x), .alvo_y(alvo_y), .alvo_l(alvo_l), .alvo_a(alvo_a),
    .bola_x(bola_x), .bola_y(bola_y), .ativa(ativa), .aliada(aliada),
    .disparo_aceito(disparo_aceito), .disparo_recusado(disparo_recusado),
    .acerto(acerto), .saiu(saiu), .raio(raio)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] px(input int i);
    return bola_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] py(input int i);
    return bola_y[10*i +: 10];
  endfunction

  task automatic target_far();
    alvo_x = 10'd0; alvo_y = 10'd0; alvo_l = 10'd0; alvo_a = 10'd0;
  endtask

  // Called at a negedge; leaves reset high so the caller releases it.
  task automatic apply_reset();
    reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0; disparar = 1'b0;
    ehAliada = 1'b0; xi = 10'd0; yi = 10'd0;
    target_far();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ativa !== 4'b0000) $display("FAIL reset_ativa: got %b want 0000", ativa); else passes++;
    checks++; if (bola_x !== {NB{10'd1000}}) $display("FAIL reset_bola_x: got %h want all 1000", bola_x); else passes++;
    checks++; if (bola_y !== {NB{10'd1000}}) $display("FAIL reset_bola_y: got %h want all 1000", bola_y); else passes++;
    checks++; if ({acerto, saiu, disparo_aceito, disparo_recusado} !== '0)
      $display("FAIL reset_pulses: got acerto=%b saiu=%b ac=%b rec=%b want 0", acerto, saiu, disparo_aceito, disparo_recusado); else passes++;
    checks++; if (raio !== 10'd5) $display("FAIL raio: got %0d want 5", raio); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_fire_and_move();
    int cyc; int n; logic [9:0] last_y; logic [15:0] e;
    apply_reset();
    reset = 1'b0; disparar = 1'b1; xi = 10'd100; yi = 10'd400; ehAliada = 1'b1;
    exp_q.push_back(16'd259); exp_q.push_back(16'd435);
    @(negedge clk); disparar = 1'b0;
    checks++; if (disparo_aceito !== 1'b1) $display("FAIL fire_aceito: got %b want 1", disparo_aceito); else passes++;
    checks++; if (ativa !== 4'b0001) $display("FAIL fire_ativa: got %b want 0001", ativa); else passes++;
    checks++; if (aliada[0] !== 1'b1) $display("FAIL fire_aliada: got %b want 1", aliada[0]); else passes++;
    e = exp_q.pop_front();
    checks++; if (px(0) !== e[9:0]) $display("FAIL fire_x: got %0d want %0d", px(0), e); else passes++;
    e = exp_q.pop_front();
    checks++; if (py(0) !== e[9:0]) $display("FAIL fire_y: got %0d want %0d", py(0), e); else passes++;
    exp_q.push_back(16'd430); exp_q.push_back(16'd425); exp_q.push_back(16'd420);
    cyc = 1; n = 0; last_y = 10'd435;
    while (exp_q.size() > 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (cyc == 2) begin
        checks++; if (disparo_aceito !== 1'b0) $display("FAIL aceito_pulse: got %b want 0", disparo_aceito); else passes++;
      end
      if (py(0) !== last_y) begin
        n++;
        e = exp_q.pop_front();
        checks++; if (py(0) !== e[9:0]) $display("FAIL move_y%0d: got %0d want %0d", n, py(0), e); else passes++;
        checks++; if (cyc != DT*n) $display("FAIL move_time%0d: got cycle %0d want %0d", n, cyc, DT*n); else passes++;
        last_y = py(0);
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL move_timeout: got %0d moves want 3", n); else passes++;
    exp_q.delete();
  endtask

  task automatic test_pool_full();
    logic [15:0] e;
    apply_reset();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      disparar = 1'b1; xi = 10'(10*(k+1)); yi = 10'd100; ehAliada = 1'b1;
      if (k < NB) exp_q.push_back(16'(10*(k+1) + 159));
      @(negedge clk);
      if (k < NB) begin
        e = exp_q.pop_front();
        checks++; if (disparo_aceito !== 1'b1 || disparo_recusado !== 1'b0)
          $display("FAIL pool_ac%0d: got ac=%b rec=%b want 1 0", k, disparo_aceito, disparo_recusado); else passes++;
        checks++; if (ativa !== 4'((1 << (k+1)) - 1)) $display("FAIL pool_ativa%0d: got %b", k, ativa); else passes++;
        checks++; if (px(k) !== e[9:0]) $display("FAIL pool_x%0d: got %0d want %0d", k, px(k), e); else passes++;
      end else begin
        checks++; if (disparo_recusado !== 1'b1 || disparo_aceito !== 1'b0)
          $display("FAIL pool_recusado: got ac=%b rec=%b want 0 1", disparo_aceito, disparo_recusado); else passes++;
        checks++; if (ativa !== 4'b1111) $display("FAIL pool_full_ativa: got %b want 1111", ativa); else passes++;
      end
    end
    disparar = 1'b0;
    for (int k = 0; k < NB; k++) exp_q.push_back(16'(10*(k+1) + 159));
    @(negedge clk);
    checks++; if (disparo_recusado !== 1'b0) $display("FAIL recusado_pulse: got %b want 0", disparo_recusado); else passes++;
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      checks++; if (px(k) !== e[9:0]) $display("FAIL pool_keep_x%0d: got %0d want %0d", k, px(k), e); else passes++;
    end
    alvo_x = 10'd179; alvo_l = 10'd0; alvo_y = 10'd0; alvo_a = 10'd1000;
    @(negedge clk);
    checks++; if (acerto !== 4'b0010) $display("FAIL pool_hit: got %b want 0010", acerto); else passes++;
    checks++; if (ativa !== 4'b1101) $display("FAIL pool_hit_ativa: got %b want 1101", ativa); else passes++;
    target_far();
    disparar = 1'b1; xi = 10'd500;
    @(negedge clk); disparar = 1'b0;
    checks++; if (disparo_aceito !== 1'b1 || ativa !== 4'b1111)
      $display("FAIL refill: got ac=%b ativa=%b want 1 1111", disparo_aceito, ativa); else passes++;
    checks++; if (px(1) !== 10'd659) $display("FAIL refill_x: got %0d want 659", px(1)); else passes++;
    checks++; if (acerto !== 4'b0000) $display("FAIL acerto_pulse: got %b want 0000", acerto); else passes++;
  endtask

  task automatic test_edges();
    int yi_t[3]   = '{4, 475, 474};
    int al_t[3]   = '{1, 0, 0};
    int exit_t[3] = '{4, 4, 8};
    int cyc; logic [15:0] e;
    for (int s = 0; s < 3; s++) begin
      apply_reset();
      reset = 1'b0; disparar = 1'b1; xi = 10'd50; yi = 10'(yi_t[s]); ehAliada = al_t[s][0];
      exp_q.push_back(16'(yi_t[s] + 35)); exp_q.push_back(16'(exit_t[s]));
      @(negedge clk); disparar = 1'b0;
      e = exp_q.pop_front();
      checks++; if (py(0) !== e[9:0]) $display("FAIL edge%0d_spawn_y: got %0d want %0d", s, py(0), e); else passes++;
      cyc = 1;
      while (saiu == '0 && cyc < 30) begin
        @(negedge clk); cyc++;
        if (s == 2 && cyc == 4) begin
          checks++; if (py(0) !== 10'd514 || ativa !== 4'b0001)
            $display("FAIL edge_514: got y=%0d ativa=%b want 514 0001", py(0), ativa); else passes++;
        end
      end
      e = exp_q.pop_front();
      checks++; if (cyc != int'(e)) $display("FAIL edge%0d_time: got cycle %0d want %0d", s, cyc, e); else passes++;
      checks++; if (saiu !== 4'b0001 || acerto !== 4'b0000)
        $display("FAIL edge%0d_saiu: got saiu=%b acerto=%b want 0001 0000", s, saiu, acerto); else passes++;
      checks++; if (ativa !== 4'b0000 || py(0) !== 10'd1000)
        $display("FAIL edge%0d_clear: got ativa=%b y=%0d want 0000 1000", s, ativa, py(0)); else passes++;
      @(negedge clk);
      checks++; if (saiu !== 4'b0000) $display("FAIL edge%0d_pulse: got %b want 0000", s, saiu); else passes++;
    end
  endtask

  task automatic test_collision();
    int cyc;
    apply_reset();
    reset = 1'b0;
    alvo_x = 10'd250; alvo_y = 10'd300; alvo_l = 10'd20; alvo_a = 10'd10;
    disparar = 1'b1; xi = 10'd100; yi = 10'd285; ehAliada = 1'b1;
    exp_q.push_back(16'd5);
    @(negedge clk); disparar = 1'b0;
    checks++; if (px(0) !== 10'd259 || py(0) !== 10'd320)
      $display("FAIL col_spawn: got x=%0d y=%0d want 259 320", px(0), py(0)); else passes++;
    cyc = 1;
    while (acerto == '0 && cyc < 30) begin
      @(negedge clk); cyc++;
      if (cyc == 4) begin
        checks++; if (py(0) !== 10'd315 || ativa !== 4'b0001)
          $display("FAIL col_315: got y=%0d ativa=%b want 315 0001", py(0), ativa); else passes++;
      end
    end
    checks++; if (cyc != int'(exp_q.pop_front())) $display("FAIL col_time: got cycle %0d want 5", cyc); else passes++;
    checks++; if (acerto !== 4'b0001 || saiu !== 4'b0000)
      $display("FAIL col_pulse: got acerto=%b saiu=%b want 0001 0000", acerto, saiu); else passes++;
    checks++; if (ativa !== 4'b0000 || py(0) !== 10'd1000)
      $display("FAIL col_clear: got ativa=%b y=%0d want 0000 1000", ativa, py(0)); else passes++;
    target_far();
  endtask

  task automatic test_pause_restart();
    int cyc; logic bad;
    apply_reset();
    reset = 1'b0; disparar = 1'b1; xi = 10'd100; yi = 10'd400; ehAliada = 1'b1;
    @(negedge clk); disparar = 1'b0;
    @(negedge clk);
    pausa = 1'b1; disparar = 1'b1; xi = 10'd300; bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (py(0) !== 10'd435 || ativa !== 4'b0001 || disparo_aceito !== 1'b0 || disparo_recusado !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL pause_frozen: got y=%0d ativa=%b want 435 0001 no pulses", py(0), ativa); else passes++;
    pausa = 1'b0; disparar = 1'b0; cyc = 0;
    exp_q.push_back(16'd430);
    while (py(0) == 10'd435 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    checks++; if (cyc != 2) $display("FAIL pause_counter: got %0d cycles to tick want 2", cyc); else passes++;
    checks++; if (py(0) !== exp_q.pop_front()) $display("FAIL pause_move: got %0d want 430", py(0)); else passes++;
    disparar = 1'b1; xi = 10'd20;
    @(negedge clk); xi = 10'd30;
    @(negedge clk); disparar = 1'b0;
    checks++; if (ativa !== 4'b0111) $display("FAIL restart_pre: got %b want 0111", ativa); else passes++;
    reiniciarJogo = 1'b1;
    @(negedge clk); reiniciarJogo = 1'b0;
    checks++; if (ativa !== 4'b0000) $display("FAIL restart_ativa: got %b want 0000", ativa); else passes++;
    checks++; if (acerto !== 4'b0000 || saiu !== 4'b0000)
      $display("FAIL restart_pulses: got acerto=%b saiu=%b want 0", acerto, saiu); else passes++;
    checks++; if (bola_x !== {NB{10'd1000}} || bola_y !== {NB{10'd1000}})
      $display("FAIL restart_pos: got x=%h y=%h want all 1000", bola_x, bola_y); else passes++;
  endtask

  initial begin
    reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0; disparar = 1'b0;
    ehAliada = 1'b0; xi = 10'd0; yi = 10'd0;
    target_far();
    @(negedge clk);
    test_reset();
    test_fire_and_move();
    test_pool_full();
    test_edges();
    test_collision();
    test_pause_restart();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
